// File: rtl/dmem_responder.sv
// dmem_responder
//   Memory end of the execute-stage load/store request. When idle, it accepts one word-aligned
//   read or write. It waits LATENCY cycles, then either commits the write or registers the
//   lane-masked read word, and signals the result with a one-cycle rsp_valid pulse.
//   Requests that are misaligned, out of range, or request both read and write get rsp_err
//   with the normal timing and do not touch the array.
// Ports
//   clk, rst_n               clock (rising edge), asynchronous active-low reset
//   req_rd, req_wr           read / write request, held by the requester until accepted
//   req_addr                 byte address
//   req_wdata                store data
//   req_rmask, req_wmask     byte-lane masks, bit i selects bits [8i+7:8i]
//   req_ready                responder idle; a request present this cycle is accepted
//   rsp_valid                one-cycle response pulse
//   rsp_rdata                masked read data (0 for writes and errors), held between responses
//   rsp_err                  request rejected, valid with rsp_valid
module dmem_responder #(
   parameter int unsigned DEPTH     = 1024,
   parameter int unsigned LATENCY   = 2,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_rd,
   input  logic        req_wr,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_rmask,
   input  logic [3:0]  req_wmask,
   output logic        req_ready,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t        state;
   logic [CW-1:0] wait_cnt;
   logic [IW-1:0] cap_idx;
   logic [31:0]   cap_wdata;
   logic [3:0]    cap_rmask;
   logic [3:0]    cap_wmask;
   logic          cap_wr;
   logic          cap_err;

   logic [31:0]   mem [DEPTH];

   logic [31:0]   index_full;
   logic          acc_err;
   logic          accept;
   logic          enter_resp;
   logic [IW-1:0] eff_idx;
   logic [31:0]   eff_wdata;
   logic [3:0]    eff_rmask;
   logic [3:0]    eff_wmask;
   logic          eff_wr;
   logic          eff_err;
   logic [31:0]   rd_masked;

   assign req_ready = (state == IDLE);

   always_comb begin
      index_full = (req_addr - BASE_ADDR) >> 2;
      acc_err    = (req_addr[1:0] != 2'b00) | (req_addr < BASE_ADDR) |
                   (index_full >= 32'(DEPTH)) | (req_rd & req_wr);
      accept     = (state == IDLE) & (req_rd | req_wr);
      enter_resp = rst_n & (((LATENCY == 0) & accept) |
                            ((state == WAIT) & (wait_cnt == '0)));
   end

   // With LATENCY=0 the array access happens on the accept edge itself, so the request
   // is taken straight from the inputs while idle, and from the capture registers otherwise.
   always_comb begin
      if (state == IDLE) begin
         eff_idx   = index_full[IW-1:0];
         eff_wdata = req_wdata;
         eff_rmask = req_rmask;
         eff_wmask = req_wmask;
         eff_wr    = req_wr;
         eff_err   = acc_err;
      end else begin
         eff_idx   = cap_idx;
         eff_wdata = cap_wdata;
         eff_rmask = cap_rmask;
         eff_wmask = cap_wmask;
         eff_wr    = cap_wr;
         eff_err   = cap_err;
      end
   end

   always_comb begin
      rd_masked = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         if (eff_rmask[i]) rd_masked[8*i +: 8] = mem[eff_idx][8*i +: 8];
      end
   end

   // Array storage is not reset.
   always_ff @(posedge clk) begin
      if (enter_resp && eff_wr && !eff_err) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (eff_wmask[i]) mem[eff_idx][8*i +: 8] <= eff_wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         cap_idx   <= '0;
         cap_wdata <= '0;
         cap_rmask <= '0;
         cap_wmask <= '0;
         cap_wr    <= 1'b0;
         cap_err   <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  cap_idx   <= index_full[IW-1:0];
                  cap_wdata <= req_wdata;
                  cap_rmask <= req_rmask;
                  cap_wmask <= req_wmask;
                  cap_wr    <= req_wr;
                  cap_err   <= acc_err;
                  if (LATENCY == 0) begin
                     state <= RESP;
                  end else begin
                     state    <= WAIT;
                     wait_cnt <= CW'(LATENCY - 1);
                  end
               end
            end
            WAIT: begin
               if (wait_cnt == '0) state <= RESP;
               else                wait_cnt <= wait_cnt - 1'b1;
            end
            RESP: state <= IDLE;
            default: state <= IDLE;
         endcase

         rsp_valid <= enter_resp;
         if (enter_resp) begin
            rsp_err   <= eff_err;
            rsp_rdata <= (eff_err || eff_wr) ? '0 : rd_masked;
         end
      end
   end

endmodule
